incr_pipe_adapter: RTL

INCR_PIPE_ADAPTER -- requirements
Module: incr_pipe_adapter

---
 rtl/incr_pipe_adapter_if.sv | 26 ++
 rtl/incr_pipe_adapter.sv | 79 +++++++
 2 files changed

// File: rtl/incr_pipe_adapter_if.sv
// rtl/incr_pipe_adapter_if.sv - handshake and pipeline signal bundle for incr_pipe_adapter
interface incr_pipe_adapter_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [WIDTH-1:0] pipe_x;
   logic [WIDTH-1:0] pipe_out;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             overflow_err;

   // adapter side of the bundle
   modport slave (
      input  in_valid, in_data, pipe_out, out_ready,
      output in_ready, pipe_x, out_valid, out_data, overflow_err
   );

   // upstream, pipeline and downstream side of the bundle
   modport master (
      output in_valid, in_data, pipe_out, out_ready,
      input  in_ready, pipe_x, out_valid, out_data, overflow_err
   );
endinterface

// File: rtl/incr_pipe_adapter.sv
// rtl/incr_pipe_adapter.sv - credit-gated adapter around a fixed-latency non-stallable incrementer pipeline
module incr_pipe_adapter #(
   parameter int WIDTH   = 32,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   incr_pipe_adapter_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [LATENCY-1:0] vld_q, vld_d;
   logic [CW-1:0]      credit_q, credit_d;
   logic [CW-1:0]      count_q, count_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic               ovf_q, ovf_d;
   logic [WIDTH-1:0]   mem_q [DEPTH];

   logic accept;
   logic pop;
   logic wr_req;
   logic full;
   logic wr_en;

   // The pipeline samples in_data every edge; the valid shift register decides what is kept.
   assign bus.pipe_x       = bus.in_data;
   // Credits cover both queued and in-flight words, so a full credit count guarantees FIFO room.
   assign bus.in_ready     = (credit_q < CW'(DEPTH));
   assign bus.out_valid    = (count_q != '0);
   assign bus.out_data     = mem_q[rd_ptr_q];
   assign bus.overflow_err = ovf_q;

   assign accept = bus.in_valid & bus.in_ready;
   assign pop    = bus.out_valid & bus.out_ready;
   assign wr_req = vld_q[LATENCY-1];
   assign full   = (count_q == CW'(DEPTH));
   // A write into a full FIFO is only safe when the head leaves in the same cycle.
   assign wr_en  = wr_req & (~full | pop);

   // Next-state for valid tracking, credits, occupancy, pointers and the sticky error.
   always_comb begin
      vld_d    = vld_q << 1;
      vld_d[0] = accept;
      credit_d = credit_q + CW'(accept) - CW'(pop);
      count_d  = count_q + CW'(wr_en) - CW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      ovf_d    = ovf_q | (wr_req & full & ~pop);
   end

   // Control state; clearing the valid bits on reset discards stale pipeline contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q    <= '0;
         credit_q <= '0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         vld_q    <= vld_d;
         credit_q <= credit_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovf_q    <= ovf_d;
      end
   end

   // FIFO storage captures the pipeline result unmodified; no reset needed on data.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= bus.pipe_out;
      end
   end
endmodule
